// File: rtl/eros_obi_rr_arbiter.sv
// eros_obi_rr_arbiter
//   N-to-1 OBI arbiter in front of one shared slave port. Masters are granted
//   in round-robin order. A request that the slave has not yet granted is
//   held, so req/addr stay stable as OBI requires. Every granted master index
//   goes into an in-order FIFO, and each rvalid/rdata is routed back to the
//   master at the FIFO head. The FIFO depth also caps how many granted
//   transactions can be waiting for a response.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous reset, active-high; also gates req/gnt/rvalid
//   master_req_i   per-master OBI request
//   master_resp_o  per-master gnt/rvalid; rdata is broadcast to all masters
//   slave_req_o    request to the shared slave
//   slave_resp_i   response from the shared slave
//   outstanding_o  registered FIFO occupancy
//   err_o          sticky: rvalid arrived while nothing was outstanding
//   dbg_state_o    arbitration FSM state (IDLE / LOCKED)
//
// Handshake semantics: a request transfers in a cycle where slave_req_o.req
// and slave_resp_i.gnt are both 1. That master's gnt is a combinational copy
// of the slave gnt. A response is one cycle with slave_resp_i.rvalid=1 and
// carries no back-pressure.

package eros_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;
endpackage

module eros_obi_rr_arbiter #(
  parameter int unsigned NMASTER         = 3,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter type         obi_req_t       = eros_obi_pkg::obi_req_t,
  parameter type         obi_resp_t      = eros_obi_pkg::obi_resp_t,
  localparam int unsigned IdxW = (NMASTER > 1) ? $clog2(NMASTER) : 1,
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  obi_req_t                master_req_i  [NMASTER],
  output obi_resp_t               master_resp_o [NMASTER],
  output obi_req_t                slave_req_o,
  input  obi_resp_t               slave_resp_i,
  output logic [CntW-1:0]         outstanding_o,
  output logic                    err_o,
  output eros_obi_pkg::arb_state_e dbg_state_o
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  eros_obi_pkg::arb_state_e state_q, state_d;

  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  logic [IdxW-1:0] winner;
  logic            winner_valid;
  logic            issue;
  logic            handshake;
  logic            pop;
  logic [IdxW-1:0] head;

  // Winner selection. While LOCKED, only the latched master may win. It
  // loses its slot only by dropping req. In IDLE the search walks from the
  // rr pointer upward with wrap-around. The loop runs from the farthest
  // offset down, so the nearest requester is written last and wins.
  always_comb begin : winner_sel
    int cand;
    winner       = '0;
    winner_valid = 1'b0;
    cand         = 0;
    if (state_q == eros_obi_pkg::ARB_LOCKED) begin
      winner       = lock_idx_q;
      winner_valid = master_req_i[lock_idx_q].req;
    end else begin
      for (int i = int'(NMASTER) - 1; i >= 0; i--) begin
        cand = int'(rr_ptr_q) + i;
        if (cand >= int'(NMASTER)) cand = cand - int'(NMASTER);
        if (master_req_i[cand].req) begin
          winner       = IdxW'(cand);
          winner_valid = 1'b1;
        end
      end
    end
  end

  // Issue depends only on registered occupancy. A same-cycle rvalid cannot
  // open a full FIFO, so no combinational path runs from rvalid to req.
  assign issue     = winner_valid && (count_q < CntW'(MAX_OUTSTANDING)) && !rst_i;
  assign handshake = issue && slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid && (count_q != '0) && !rst_i;
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    slave_req_o     = master_req_i[0];
    slave_req_o.req = 1'b0;
    if (issue) slave_req_o = master_req_i[winner];
    for (int i = 0; i < int'(NMASTER); i++) begin
      master_resp_o[i].gnt    = handshake && (winner == IdxW'(i));
      master_resp_o[i].rvalid = pop && (head == IdxW'(i));
      master_resp_o[i].rdata  = slave_resp_i.rdata;
    end
  end

  // Next state: a completed handshake always returns to IDLE. An issued but
  // ungranted request locks. A locked master that drops req releases the lock.
  always_comb begin
    state_d = state_q;
    if (handshake) begin
      state_d = eros_obi_pkg::ARB_IDLE;
    end else if (issue) begin
      state_d = eros_obi_pkg::ARB_LOCKED;
    end else if (state_q == eros_obi_pkg::ARB_LOCKED && !winner_valid) begin
      state_d = eros_obi_pkg::ARB_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= eros_obi_pkg::ARB_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue && !slave_resp_i.gnt) lock_idx_q <= winner;
      if (handshake) begin
        rr_ptr_q <= (winner == IdxW'(NMASTER - 1)) ? '0 : winner + IdxW'(1);
        wr_ptr_q <= (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(handshake) - CntW'(pop);
      if (slave_resp_i.rvalid && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset because the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && handshake) fifo_q[wr_ptr_q] <= winner;
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_eros_obi_rr_arbiter.sv
// Testbench for eros_obi_rr_arbiter (NMASTER=3, MAX_OUTSTANDING=2).
// A reference model holds the routing order in a queue of master indices,
// the round-robin start position as an integer, and the held master (or -1).
// Each step drives inputs just after a rising edge. Mid-cycle it checks every
// output against the model, then advances the model on the next edge.

module tb_eros_obi_rr_arbiter;
  import eros_obi_pkg::*;

  localparam int N    = 3;
  localparam int MAXO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  obi_req_t   mreq  [N];
  obi_resp_t  mresp [N];
  obi_req_t   sreq;
  obi_resp_t  sresp;
  logic [1:0] outstanding;
  logic       err;
  arb_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  int q[$];
  int rr_start = 0;
  int held     = -1;
  bit m_err    = 1'b0;

  always #5 clk = ~clk;

  eros_obi_rr_arbiter #(.NMASTER(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .master_req_i (mreq),
    .master_resp_o(mresp),
    .slave_req_o  (sreq),
    .slave_resp_i (sresp),
    .outstanding_o(outstanding),
    .err_o        (err),
    .dbg_state_o  (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, clock the model.
  task automatic step(input bit r, input logic [N-1:0] reqs, input bit g,
                      input bit rv, input logic [31:0] rd);
    int  win;
    int  head;
    bit  wvalid;
    bit  issue;
    bit  pop;
    rst = r;
    for (int i = 0; i < N; i++) begin
      mreq[i].req   = reqs[i];
      mreq[i].we    = 1'($urandom_range(0, 1));
      mreq[i].be    = 4'($urandom);
      mreq[i].addr  = {8'(8'hA0 + i), 24'($urandom)};
      mreq[i].wdata = $urandom;
    end
    sresp.gnt    = g;
    sresp.rvalid = rv;
    sresp.rdata  = rd;
    #3;
    win    = 0;
    wvalid = 1'b0;
    if (held >= 0) begin
      win    = held;
      wvalid = reqs[held];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr_start + k) % N;
        if (!wvalid && reqs[c]) begin
          win    = c;
          wvalid = 1'b1;
        end
      end
    end
    issue = wvalid && (q.size() < MAXO) && !r;
    pop   = rv && (q.size() > 0) && !r;
    head  = (q.size() > 0) ? q[0] : -1;

    chk("outstanding", outstanding, q.size());
    chk("err", err, m_err);
    chk("locked", dbg_state == ARB_LOCKED, held >= 0);
    chk("slave_req", sreq.req, issue);
    if (issue) begin
      chk("slave_addr", sreq.addr, mreq[win].addr);
      chk("slave_wdata", sreq.wdata, mreq[win].wdata);
      chk("slave_we_be", {sreq.we, sreq.be}, {mreq[win].we, mreq[win].be});
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("gnt%0d", i), mresp[i].gnt, issue && g && (win == i));
      chk($sformatf("rvalid%0d", i), mresp[i].rvalid, pop && (head == i));
      chk($sformatf("rdata%0d", i), mresp[i].rdata, rd);
    end

    @(posedge clk);
    if (r) begin
      q.delete();
      rr_start = 0;
      held     = -1;
      m_err    = 1'b0;
    end else begin
      if (rv) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1'b1;
      end
      if (issue && g) begin
        q.push_back(win);
        rr_start = (win + 1) % N;
        held     = -1;
      end else if (issue) begin
        held = win;
      end else if (held >= 0 && !reqs[held]) begin
        held = -1;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mreq[i] = '0;
    sresp = '0;
    @(posedge clk);
    #1;

    // reset held: everything gated even with requests and gnt present
    step(1, 3'b111, 1, 0, 32'h0);
    step(1, 3'b111, 1, 1, 32'h0);

    // fairness: all request, gnt every cycle, rvalid one cycle later
    for (int c = 0; c < 6; c++) step(0, 3'b111, 1, c > 0, $urandom);
    step(0, 3'b000, 0, 1, $urandom);
    chk("fair_drain", outstanding, 0);

    // lock: master 1 waits 3 cycles, master 0 joins in cycle 2
    step(0, 3'b010, 0, 0, 32'h0);
    step(0, 3'b011, 0, 0, 32'h0);
    step(0, 3'b011, 0, 0, 32'h0);
    step(0, 3'b011, 1, 0, 32'h0);
    step(0, 3'b001, 1, 0, 32'h0);
    step(0, 3'b000, 0, 1, $urandom);
    step(0, 3'b000, 0, 1, $urandom);

    // full stall: two grants, master 2 blocked until a pop
    step(0, 3'b011, 1, 0, 32'h0);
    step(0, 3'b011, 1, 0, 32'h0);
    chk("full_occ", outstanding, 2);
    step(0, 3'b100, 1, 0, 32'h0);
    step(0, 3'b100, 1, 1, $urandom);
    chk("pop_occ", outstanding, 1);
    step(0, 3'b100, 1, 0, 32'h0);
    step(0, 3'b000, 0, 1, $urandom);
    step(0, 3'b000, 0, 1, $urandom);

    // routing order: masters 2 then 0, responses in issue order
    step(0, 3'b100, 1, 0, 32'h0);
    step(0, 3'b001, 1, 0, 32'h0);
    step(0, 3'b000, 0, 1, 32'hAAAA0000);
    step(0, 3'b000, 0, 1, 32'h5555FFFF);

    // push and pop in the same cycle
    step(0, 3'b010, 1, 0, 32'h0);
    step(0, 3'b100, 1, 1, 32'h12345678);
    chk("pushpop_occ", outstanding, 1);
    step(0, 3'b000, 0, 1, 32'h87654321);

    // reset mid-operation, then a stray response
    step(0, 3'b011, 1, 0, 32'h0);
    step(0, 3'b011, 1, 0, 32'h0);
    step(1, 3'b000, 0, 0, 32'h0);
    step(0, 3'b000, 0, 1, 32'hDEADBEEF);
    chk("stray_err", err, 1);
    step(0, 3'b111, 1, 0, 32'h0);
    step(0, 3'b000, 0, 1, $urandom);

    // randomized traffic including dropped locked requests and resets
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 49) == 0, 3'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eros_obi_rr_arbiter.md
Name: eros_obi_rr_arbiter

Overview:
- N-to-1 OBI arbiter feeding a single shared slave port, for example the neck of the 1-to-M system crossbar.
- Grants masters in round-robin order.
- Holds a request stable until the slave grants it, so the OBI req/addr stay stable.
- Keeps an in-order FIFO of granted master indices, so each rvalid/rdata goes back to the master that issued it.
- Caps the number of outstanding transactions.

Parameters:
- NMASTER, 3, number of requesting masters (>=2).
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO = maximum granted-but-unanswered transactions (>=1).
- obi_req_t, logic, OBI request struct {req, we, be[3:0], addr[31:0], wdata[31:0]}.
- obi_resp_t, logic, OBI response struct {gnt, rvalid, rdata[31:0]}.
- IdxW (localparam), max(1,$clog2(NMASTER)), master index width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- master_req_i  in  NMASTER x obi_req_t  requests from masters.
- master_resp_o  out  NMASTER x obi_resp_t  per-master gnt/rvalid/rdata.
- slave_req_o  out  obi_req_t  request to the shared slave.
- slave_resp_i  in  obi_resp_t  response from the shared slave.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- err_o  out  1  sticky: an rvalid arrived with an empty FIFO.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - rr pointer=0, lock cleared, FIFO empty, err_o=0.
  - While rst_i is high: slave_req_o.req=0 and all master gnt/rvalid=0 (combinational gating).
  - Reset mid-operation discards all outstanding entries; a later stray rvalid sets err_o.
- Arbitration state machine:
  - IDLE: winner = first master with req=1, searching from rr pointer upward with wrap-around (NMASTER-1 -> 0).
  - LOCKED: winner = latched index.
- Issue condition: issue = winner valid AND occupancy < MAX_OUTSTANDING.
  - Full blocks issue even if rvalid pops in the same cycle; no rvalid->req combinational path.
- Request forwarding when issue=1:
  - slave_req_o = master_req_i[winner].
  - master_resp_o[winner].gnt = slave_resp_i.gnt.
  - All other gnt=0.
- When issue=0: slave_req_o.req=0; other slave_req_o fields are don't-care but driven from master 0.
- Handshake = issue AND slave_resp_i.gnt:
  - push winner into FIFO.
  - rr pointer <= (winner+1) mod NMASTER.
  - state -> IDLE.
- issue AND NOT gnt: latch winner, state -> LOCKED.
  - The next cycle must present the same master, even if a higher-priority master raises req.
- LOCKED with the locked master dropping req (protocol violation): state -> IDLE, no push, pointer unchanged.
- Zero-latency grant: gnt is combinational from slave_resp_i.gnt; no added cycle on the request path.
- Response path:
  - rvalid=1 with FIFO non-empty: master_resp_o[head].rvalid=1, rdata=slave_resp_i.rdata; pop.
  - rdata is broadcast to all masters; only head sees rvalid.
  - rvalid=1 with FIFO empty: no master rvalid, err_o<=1 (held until reset).
- Simultaneous push and pop in one cycle: occupancy unchanged, FIFO order preserved.
- rvalid may coincide with gnt of a new request in the same cycle (back-to-back); both are handled.
- Pointers wrap modulo MAX_OUTSTANDING; non-power-of-2 depths are supported.
- outstanding_o is the registered occupancy.

Test Plan:
- Fairness: masters 0,1,2 hold req=1, slave gnt=1 every cycle, rvalid 1 cycle after each gnt, MAX_OUTSTANDING=2 -> grant order 0,1,2,0,1,2; each master sees rvalid exactly one cycle after its own gnt.
- Lock: master 1 reqs, slave gnt=0 for 3 cycles, master 0 raises req in cycle 2 -> slave_req_o.addr stays master 1's for all 4 cycles; master 1 granted in cycle 4; master 0 granted next.
- Full stall: MAX_OUTSTANDING=2, two grants with no rvalid -> outstanding_o=2, slave_req_o.req=0 while master 2 requests; rvalid pops -> outstanding_o=1, master 2 issued the following cycle.
- Routing order: grants to masters 2 then 0, responses with rdata 0xAAAA0000 then 0x5555FFFF -> master 2 gets 0xAAAA0000 with rvalid, master 0 gets 0x5555FFFF.
- Push+pop same cycle: occupancy 1, new gnt and rvalid in the same cycle -> outstanding_o stays 1, head advances to the new master.
- Reset mid-op: 2 outstanding, rst_i pulsed 1 cycle, then slave rvalid=1 -> no master rvalid, err_o=1, outstanding_o=0, next grant goes to master 0 first.
